// File: rtl/fetch_queue_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit_if
// Handshake bundle between the fetch front-end, the instruction cache and the
// decode stage.
//   icache request  : icache_req_valid / icache_req_ready / icache_req_addr
//   icache response : icache_rsp_valid / icache_rsp_data (single-cycle pulse)
//   decode          : decode_valid / decode_ready / decode_instr_data / decode_instr_pc
// modport master : fetch unit side
// modport slave  : icache + decode side (environment)
// ---------------------------------------------------------------------------
interface fetch_queue_unit_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int LINE_WIDTH  = 128
);
    logic                   icache_req_valid;
    logic                   icache_req_ready;
    logic [PC_WIDTH-1:0]    icache_req_addr;
    logic                   icache_rsp_valid;
    logic [LINE_WIDTH-1:0]  icache_rsp_data;
    logic                   decode_valid;
    logic                   decode_ready;
    logic [INSTR_WIDTH-1:0] decode_instr_data;
    logic [PC_WIDTH-1:0]    decode_instr_pc;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_req_ready, icache_rsp_valid, icache_rsp_data,
        output decode_valid, decode_instr_data, decode_instr_pc,
        input  decode_ready
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_req_ready, icache_rsp_valid, icache_rsp_data,
        input  decode_valid, decode_instr_data, decode_instr_pc,
        output decode_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
// Decoupled fetch front-end: generates the PC, issues one icache line request
// at a time, splits each returned line into instructions and buffers them in
// a circular queue feeding decode. Branch redirects flush the queue and
// discard any in-flight response.
// Ports:
//   clock, reset     : core clock, asynchronous active-low reset
//   boot_addr        : PC loaded while reset is asserted
//   take_branch      : redirect pulse, branch_pc is the (word-aligned) target
//   bus (master)     : icache request/response and decode handshakes
//   queue_count      : occupied queue entries
// Optional (define FETCH_PERF_CNT_EN): saturating 32-bit performance counters
//   perf_lines_fetched, perf_instrs_delivered, perf_redirects,
//   perf_starve_cycles.
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTR_WIDTH       = 32,
    parameter int LINE_WIDTH        = 128,
    parameter int FETCH_QUEUE_DEPTH = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [PC_WIDTH-1:0]                 boot_addr,
    input  logic                                take_branch,
    input  logic [PC_WIDTH-1:0]                 branch_pc,
    fetch_queue_unit_if.master                  bus,
    output logic [$clog2(FETCH_QUEUE_DEPTH):0]  queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                         perf_lines_fetched,
    output logic [31:0]                         perf_instrs_delivered,
    output logic [31:0]                         perf_redirects,
    output logic [31:0]                         perf_starve_cycles
`endif
);
    localparam int IPL         = LINE_WIDTH / INSTR_WIDTH;
    localparam int INSTR_BYTES = INSTR_WIDTH / 8;
    localparam int LINE_BYTES  = LINE_WIDTH / 8;
    localparam int OFF_W       = $clog2(INSTR_BYTES);
    localparam int PTR_W       = $clog2(FETCH_QUEUE_DEPTH);
    localparam int CNT_W       = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
    logic                   drop_q, drop_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [INSTR_WIDTH-1:0] instr_q [FETCH_QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_d [FETCH_QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]    ipc_q   [FETCH_QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]    ipc_d   [FETCH_QUEUE_DEPTH];

    logic [CNT_W-1:0] need_fetch, free_slots, rsp_word, rsp_need, ofs;
    logic [PTR_W-1:0] slot;
    logic             can_req, enq, deq, rsp_hit;

    // Index of a PC's instruction within its cache line.
    function automatic logic [CNT_W-1:0] word_idx(input logic [PC_WIDTH-1:0] pc);
        logic [PC_WIDTH-1:0] w;
        w = (pc >> OFF_W) & PC_WIDTH'(IPL - 1);
        return CNT_W'(w);
    endfunction

    assign need_fetch = CNT_W'(IPL) - word_idx(fetch_pc_q);
    assign free_slots = CNT_W'(FETCH_QUEUE_DEPTH) - count_q;
    // Free-slot check ignores a same-cycle dequeue, so the queue never overflows.
    assign can_req    = !take_branch && (free_slots >= need_fetch);
    // req_addr_q is the PC of the outstanding request; it stays valid in RSP
    // even after a redirect has moved fetch_pc_q.
    assign rsp_word   = word_idx(req_addr_q);
    assign rsp_need   = CNT_W'(IPL) - rsp_word;
    assign rsp_hit    = (state_q == RSP) && bus.icache_rsp_valid;
    assign enq        = rsp_hit && !drop_q && !take_branch;
    assign deq        = (count_q != '0) && bus.decode_ready;

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_req) state_d = REQ;
            REQ:     if (bus.icache_req_ready) state_d = RSP;
            RSP:     if (bus.icache_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.icache_req_valid  = (state_q == REQ);
        bus.icache_req_addr   = req_addr_q;
        bus.decode_valid      = (count_q != '0);
        bus.decode_instr_data = instr_q[rd_ptr_q];
        bus.decode_instr_pc   = ipc_q[rd_ptr_q];
        queue_count           = count_q;
    end

    // PC, request address and drop flag
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        if (state_q == IDLE && can_req) req_addr_d = fetch_pc_q;
        if (rsp_hit) drop_d = 1'b0;
        if (enq) fetch_pc_d = (req_addr_q & ~PC_WIDTH'(LINE_BYTES - 1)) + PC_WIDTH'(LINE_BYTES);
        if (take_branch) begin
            fetch_pc_d = branch_pc & ~PC_WIDTH'(INSTR_BYTES - 1);
            // A response is still owed: mark it stale so it is thrown away on arrival.
            if (state_q == REQ || (state_q == RSP && !bus.icache_rsp_valid)) drop_d = 1'b1;
        end
    end

    // Queue pointers, occupancy and storage
    always_comb begin
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ofs      = '0;
        slot     = '0;
        if (take_branch) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (enq) begin
                for (int i = 0; i < IPL; i++) begin
                    if (CNT_W'(i) >= rsp_word) begin
                        ofs          = CNT_W'(i) - rsp_word;
                        slot         = wr_ptr_q + PTR_W'(ofs);
                        instr_d[slot] = bus.icache_rsp_data[i*INSTR_WIDTH +: INSTR_WIDTH];
                        ipc_d[slot]   = req_addr_q + (PC_WIDTH'(ofs) << OFF_W);
                    end
                end
                wr_ptr_d = wr_ptr_q + PTR_W'(rsp_need);
            end
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + (enq ? rsp_need : '0) - (deq ? CNT_W'(1) : '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= boot_addr;
            drop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue contents and request address carry no reset; occupancy and FSM
    // state decide whether they are meaningful.
    always_ff @(posedge clock) begin
        instr_q    <= instr_d;
        ipc_q      <= ipc_d;
        req_addr_q <= req_addr_d;
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    logic [31:0] lines_q, lines_d, instrs_q, instrs_d, redir_q, redir_d, starve_q, starve_d;

    always_comb begin
        lines_d  = sat_inc(lines_q, enq);
        instrs_d = sat_inc(instrs_q, deq);
        redir_d  = sat_inc(redir_q, take_branch);
        starve_d = sat_inc(starve_q, bus.decode_ready && (count_q == '0));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lines_q  <= '0;
            instrs_q <= '0;
            redir_q  <= '0;
            starve_q <= '0;
        end else begin
            lines_q  <= lines_d;
            instrs_q <= instrs_d;
            redir_q  <= redir_d;
            starve_q <= starve_d;
        end
    end

    assign perf_lines_fetched    = lines_q;
    assign perf_instrs_delivered = instrs_q;
    assign perf_redirects        = redir_q;
    assign perf_starve_cycles    = starve_q;
`endif
endmodule
